// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm zone controller: state encodings,
// keypad result codes and field widths.
package alarm_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned FAIL_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4,
        ST_SILENT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        KEY_NONE = 2'd0,
        KEY_GOOD = 2'd1,
        KEY_BAD  = 2'd2
    } key_res_e;

    // KEY_OK is only meaningful while KEY_VALID is high.
    function automatic key_res_e key_decode(input logic valid, input logic ok);
        if (!valid) return KEY_NONE;
        return ok ? KEY_GOOD : KEY_BAD;
    endfunction

endpackage

// File: rtl/delay_counter.sv
// Loadable down counter shared by the EXIT, ENTRY and ALARM timers.
// Ports: clk, rst (sync, active-high), load/load_val, en, zero_c (count == 0).
module delay_counter #(
    parameter int unsigned CNT_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority; decrement stops at zero, never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/alarm_zone_ctrl.sv
// Intruder alarm zone controller: exit/entry delays, instant and delayed
// zones, zone bypass, siren timeout and wrong-code lockout.
// Ports: CLK, RST (sync, active-high), SENSOR_IN/ZONE_DELAYED/ZONE_MASK
// per-zone vectors, KEY_VALID/KEY_OK keypad result, STATE, SIREN_OUT,
// ARMED_OUT, TRIG_ZONES (latched culprits), FAIL_CNT (wrong-code count).
module alarm_zone_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned N_ZONES     = 4,
    parameter int unsigned CNT_W       = 18,
    parameter int unsigned EXIT_DELAY  = 15000,
    parameter int unsigned ENTRY_DELAY = 15000,
    parameter int unsigned SIREN_MAX   = 60000,
    parameter int unsigned MAX_FAILS   = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_ZONES-1:0] SENSOR_IN,
    input  logic [N_ZONES-1:0] ZONE_DELAYED,
    input  logic [N_ZONES-1:0] ZONE_MASK,
    input  logic               KEY_VALID,
    input  logic               KEY_OK,
    output logic [STATE_W-1:0] STATE,
    output logic               SIREN_OUT,
    output logic               ARMED_OUT,
    output logic [N_ZONES-1:0] TRIG_ZONES,
    output logic [FAIL_W-1:0]  FAIL_CNT
);

    // MAX_FAILS is expected in 1..3 so that the saturating count can reach it.
    localparam logic [FAIL_W-1:0] MAX_FAILS_L = FAIL_W'(MAX_FAILS);
    localparam logic [FAIL_W-1:0] FAIL_SAT    = '1;

    state_e             state_q, state_d;
    logic [FAIL_W-1:0]  fail_q, fail_d, fail_inc;
    logic [N_ZONES-1:0] trig_q, trig_d;
    logic               siren_q, armed_q;
    logic [N_ZONES-1:0] inst, dly;
    key_res_e           key;
    logic               bad_armed, forced;
    logic               cnt_load, cnt_en, cnt_zero;
    logic [CNT_W-1:0]   cnt_load_val;

    assign inst = SENSOR_IN & ~ZONE_MASK & ~ZONE_DELAYED;
    assign dly  = SENSOR_IN & ~ZONE_MASK &  ZONE_DELAYED;

    // Next-state, lockout counter and trigger latch.
    always_comb begin
        state_d   = state_q;
        fail_d    = fail_q;
        trig_d    = trig_q;
        key       = key_decode(KEY_VALID, KEY_OK);
        fail_inc  = (fail_q == FAIL_SAT) ? fail_q : fail_q + FAIL_W'(1);
        bad_armed = (key == KEY_BAD) && (state_q != ST_DISARMED);
        forced    = bad_armed && (fail_inc >= MAX_FAILS_L);

        if (bad_armed) begin
            fail_d = fail_inc;
        end

        if (key == KEY_GOOD) begin
            state_d = (state_q == ST_DISARMED) ? ST_EXIT : ST_DISARMED;
            fail_d  = '0;
        end else begin
            case (state_q)
                ST_DISARMED: state_d = ST_DISARMED;
                ST_EXIT: begin
                    if (forced)        state_d = ST_ALARM;
                    else if (cnt_zero) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (forced || (|inst)) begin
                        state_d = ST_ALARM;
                        trig_d  = trig_q | inst | dly;
                    end else if (|dly) begin
                        state_d = ST_ENTRY;
                        trig_d  = trig_q | dly;
                    end
                end
                ST_ENTRY: begin
                    if (forced || (|inst) || cnt_zero) begin
                        state_d = ST_ALARM;
                        trig_d  = trig_q | inst | dly;
                    end
                end
                // Further wrong codes only count here; the siren runs out.
                ST_ALARM: begin
                    if (cnt_zero) state_d = ST_SILENT;
                end
                ST_SILENT: begin
                    if (forced || (|(inst | dly))) begin
                        state_d = ST_ALARM;
                        trig_d  = trig_q | inst | dly;
                    end
                end
                default: state_d = ST_DISARMED;
            endcase
        end

        if (state_d == ST_DISARMED) begin
            trig_d = '0;
            fail_d = '0;
        end
    end

    // Timer reload on every state change; timed states load delay-1 so the
    // state is held for exactly the configured number of cycles.
    always_comb begin
        cnt_load     = (state_d != state_q);
        cnt_en       = (state_q == ST_EXIT) || (state_q == ST_ENTRY) || (state_q == ST_ALARM);
        cnt_load_val = '0;
        case (state_d)
            ST_EXIT:  cnt_load_val = CNT_W'(EXIT_DELAY - 1);
            ST_ENTRY: cnt_load_val = CNT_W'(ENTRY_DELAY - 1);
            ST_ALARM: cnt_load_val = CNT_W'(SIREN_MAX - 1);
            default:  cnt_load_val = '0;
        endcase
    end

    delay_counter #(
        .CNT_W (CNT_W)
    ) u_delay_counter (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero_c   (cnt_zero)
    );

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_DISARMED;
            fail_q  <= '0;
            trig_q  <= '0;
            siren_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
            trig_q  <= trig_d;
            siren_q <= (state_d == ST_ALARM);
            armed_q <= (state_d != ST_DISARMED);
        end
    end

    assign STATE      = state_q;
    assign SIREN_OUT  = siren_q;
    assign ARMED_OUT  = armed_q;
    assign TRIG_ZONES = trig_q;
    assign FAIL_CNT   = fail_q;

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
module tb_alarm_zone_ctrl;

    localparam int EXIT_D  = 3;
    localparam int ENTRY_D = 4;
    localparam int SIREN_D = 5;
    localparam int MAXF    = 3;

    logic       CLK;
    logic       RST;
    logic [3:0] SENSOR_IN, ZONE_DELAYED, ZONE_MASK;
    logic       KEY_VALID, KEY_OK;
    logic [2:0] STATE;
    logic       SIREN_OUT, ARMED_OUT;
    logic [3:0] TRIG_ZONES;
    logic [1:0] FAIL_CNT;

    int checks   = 0;
    int failures = 0;

    // Reference model: state number, cycles spent in state, lockout count, culprits.
    int         m_state = 0;
    int         m_age   = 0;
    int         m_fail  = 0;
    logic [3:0] m_trig  = '0;

    alarm_zone_ctrl #(
        .N_ZONES     (4),
        .CNT_W       (18),
        .EXIT_DELAY  (EXIT_D),
        .ENTRY_DELAY (ENTRY_D),
        .SIREN_MAX   (SIREN_D),
        .MAX_FAILS   (MAXF)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .SENSOR_IN    (SENSOR_IN),
        .ZONE_DELAYED (ZONE_DELAYED),
        .ZONE_MASK    (ZONE_MASK),
        .KEY_VALID    (KEY_VALID),
        .KEY_OK       (KEY_OK),
        .STATE        (STATE),
        .SIREN_OUT    (SIREN_OUT),
        .ARMED_OUT    (ARMED_OUT),
        .TRIG_ZONES   (TRIG_ZONES),
        .FAIL_CNT     (FAIL_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural rules: 0 DISARMED, 1 EXIT, 2 ARMED, 3 ENTRY, 4 ALARM, 5 SILENT.
    task automatic model_update(input logic rst, input logic [3:0] s, d, m,
                                input logic kv, ko);
        logic [3:0] inst, dly;
        int  nxt, nfail;
        bit  forced, latch;
        inst = s & ~m & ~d;
        dly  = s & ~m & d;
        if (rst) begin
            m_state = 0; m_age = 0; m_fail = 0; m_trig = '0;
            return;
        end
        nxt    = m_state;
        nfail  = m_fail;
        forced = 0;
        latch  = 0;
        if (kv && ko) begin
            nxt   = (m_state == 0) ? 1 : 0;
            nfail = 0;
        end else begin
            if (kv && !ko && m_state != 0) begin
                nfail  = (m_fail < 3) ? m_fail + 1 : 3;
                forced = (nfail >= MAXF);
            end
            case (m_state)
                1: if (forced) nxt = 4; else if (m_age == EXIT_D) nxt = 2;
                2: if (forced || inst != 0) begin nxt = 4; latch = 1; end
                   else if (dly != 0) begin nxt = 3; latch = 1; end
                3: if (forced || inst != 0 || m_age == ENTRY_D) begin nxt = 4; latch = 1; end
                4: if (m_age == SIREN_D) nxt = 5;
                5: if (forced || (inst | dly) != 0) begin nxt = 4; latch = 1; end
                default: ;
            endcase
        end
        if (latch) m_trig = m_trig | inst | dly;
        if (nxt == 0) begin m_trig = '0; nfail = 0; end
        m_age   = (nxt != m_state) ? 1 : m_age + 1;
        m_state = nxt;
        m_fail  = nfail;
    endtask

    // Apply one cycle of inputs, clock it, advance the model, settle.
    task automatic step(input logic rst, input logic [3:0] s, d, m,
                        input logic kv, ko);
        RST = rst; SENSOR_IN = s; ZONE_DELAYED = d; ZONE_MASK = m;
        KEY_VALID = kv; KEY_OK = ko;
        @(posedge CLK);
        model_update(rst, s, d, m, kv, ko);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    endtask

    task automatic good_code();
        step(1'b0, 4'b0, 4'b0, 4'b0, 1'b1, 1'b1);
    endtask

    task automatic arm_system();
        good_code();
        repeat (EXIT_D) idle();
    endtask

    task automatic test_reset();
        step(1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
        checks++;
        if (STATE !== 3'd0 || SIREN_OUT !== 1'b0 || ARMED_OUT !== 1'b0 ||
            TRIG_ZONES !== 4'b0 || FAIL_CNT !== 2'd0) begin
            failures++;
            $display("FAIL reset_state state=%0d siren=%b armed=%b trig=%b fail=%0d expected all zero",
                     STATE, SIREN_OUT, ARMED_OUT, TRIG_ZONES, FAIL_CNT);
        end
    endtask

    task automatic test_exit_alarm();
        good_code();
        checks++;
        if (STATE !== 3'd1 || ARMED_OUT !== 1'b1) begin
            failures++; $display("FAIL exit_enter state=%0d armed=%b expected 1/1", STATE, ARMED_OUT);
        end
        repeat (EXIT_D - 1) idle();
        checks++;
        if (STATE !== 3'd1) begin
            failures++; $display("FAIL exit_hold state=%0d expected 1", STATE);
        end
        idle();
        checks++;
        if (STATE !== 3'd2) begin
            failures++; $display("FAIL exit_to_armed state=%0d expected 2", STATE);
        end
        step(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checks++;
        if (STATE !== 3'd4 || TRIG_ZONES !== 4'b0100 || SIREN_OUT !== 1'b1) begin
            failures++;
            $display("FAIL instant_alarm state=%0d trig=%b siren=%b expected 4/0100/1",
                     STATE, TRIG_ZONES, SIREN_OUT);
        end
        for (int i = 1; i < SIREN_D; i++) begin
            idle();
            checks++;
            if (STATE !== 3'd4 || SIREN_OUT !== 1'b1) begin
                failures++; $display("FAIL siren_hold cyc=%0d state=%0d siren=%b expected 4/1", i, STATE, SIREN_OUT);
            end
        end
        idle();
        checks++;
        if (STATE !== 3'd5 || SIREN_OUT !== 1'b0 || TRIG_ZONES !== 4'b0100) begin
            failures++;
            $display("FAIL siren_timeout state=%0d siren=%b trig=%b expected 5/0/0100",
                     STATE, SIREN_OUT, TRIG_ZONES);
        end
        good_code();
        checks++;
        if (STATE !== 3'd0 || TRIG_ZONES !== 4'b0 || ARMED_OUT !== 1'b0) begin
            failures++; $display("FAIL silent_disarm state=%0d trig=%b armed=%b expected 0/0000/0",
                                 STATE, TRIG_ZONES, ARMED_OUT);
        end
    endtask

    task automatic test_entry_disarm();
        bit siren_seen;
        siren_seen = 0;
        arm_system();
        step(1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0);
        siren_seen |= SIREN_OUT;
        checks++;
        if (STATE !== 3'd3 || TRIG_ZONES !== 4'b0001) begin
            failures++; $display("FAIL entry_enter state=%0d trig=%b expected 3/0001", STATE, TRIG_ZONES);
        end
        step(1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0);
        siren_seen |= SIREN_OUT;
        step(1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b1);
        siren_seen |= SIREN_OUT;
        checks++;
        if (STATE !== 3'd0 || TRIG_ZONES !== 4'b0 || siren_seen !== 1'b0) begin
            failures++; $display("FAIL entry_disarm state=%0d trig=%b siren_seen=%b expected 0/0000/0",
                                 STATE, TRIG_ZONES, siren_seen);
        end
    endtask

    task automatic test_entry_timeout();
        arm_system();
        step(1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0);
        for (int i = 1; i < ENTRY_D; i++) begin
            idle();
            checks++;
            if (STATE !== 3'd3 || SIREN_OUT !== 1'b0) begin
                failures++; $display("FAIL entry_hold cyc=%0d state=%0d siren=%b expected 3/0", i, STATE, SIREN_OUT);
            end
        end
        idle();
        checks++;
        if (STATE !== 3'd4 || SIREN_OUT !== 1'b1 || TRIG_ZONES !== 4'b0001) begin
            failures++; $display("FAIL entry_timeout state=%0d siren=%b trig=%b expected 4/1/0001",
                                 STATE, SIREN_OUT, TRIG_ZONES);
        end
        good_code();
        arm_system();
        step(1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0);
        step(1'b0, 4'b0100, 4'b0001, 4'b0000, 1'b0, 1'b0);
        checks++;
        if (STATE !== 3'd4 || TRIG_ZONES !== 4'b0101) begin
            failures++; $display("FAIL entry_instant state=%0d trig=%b expected 4/0101", STATE, TRIG_ZONES);
        end
        good_code();
    endtask

    task automatic test_wrong_codes();
        arm_system();
        for (int i = 1; i <= MAXF; i++) begin
            step(1'b0, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0);
            checks++;
            if (FAIL_CNT !== 2'(i) || STATE !== ((i == MAXF) ? 3'd4 : 3'd2)) begin
                failures++; $display("FAIL wrong_code n=%0d fail=%0d state=%0d", i, FAIL_CNT, STATE);
            end
        end
        good_code();
        checks++;
        if (STATE !== 3'd0 || FAIL_CNT !== 2'd0) begin
            failures++; $display("FAIL lockout_disarm state=%0d fail=%0d expected 0/0", STATE, FAIL_CNT);
        end
        step(1'b0, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0);
        checks++;
        if (STATE !== 3'd0 || FAIL_CNT !== 2'd0) begin
            failures++; $display("FAIL disarmed_wrong state=%0d fail=%0d expected 0/0", STATE, FAIL_CNT);
        end
        step(1'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b1);
        checks++;
        if (STATE !== 3'd0) begin
            failures++; $display("FAIL ok_without_valid state=%0d expected 0", STATE);
        end
    endtask

    task automatic test_mask();
        arm_system();
        repeat (3) step(1'b0, 4'b1111, 4'b0011, 4'b1111, 1'b0, 1'b0);
        checks++;
        if (STATE !== 3'd2 || TRIG_ZONES !== 4'b0) begin
            failures++; $display("FAIL mask_all state=%0d trig=%b expected 2/0000", STATE, TRIG_ZONES);
        end
        step(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1);
        checks++;
        if (STATE !== 3'd0 || TRIG_ZONES !== 4'b0 || SIREN_OUT !== 1'b0) begin
            failures++; $display("FAIL code_beats_sensor state=%0d trig=%b siren=%b expected 0/0000/0",
                                 STATE, TRIG_ZONES, SIREN_OUT);
        end
    endtask

    task automatic test_reset_in_alarm();
        arm_system();
        step(1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b0);
        checks++;
        if (STATE !== 3'd4 || SIREN_OUT !== 1'b1) begin
            failures++; $display("FAIL pre_reset_alarm state=%0d siren=%b expected 4/1", STATE, SIREN_OUT);
        end
        step(1'b1, 4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b1);
        checks++;
        if (STATE !== 3'd0 || SIREN_OUT !== 1'b0 || ARMED_OUT !== 1'b0 ||
            TRIG_ZONES !== 4'b0 || FAIL_CNT !== 2'd0) begin
            failures++;
            $display("FAIL reset_in_alarm state=%0d siren=%b armed=%b trig=%b fail=%0d expected all zero",
                     STATE, SIREN_OUT, ARMED_OUT, TRIG_ZONES, FAIL_CNT);
        end
        idle();
    endtask

    task automatic test_random();
        logic [3:0] s, d, m;
        logic       r, kv, ko;
        d = 4'($urandom);
        m = 4'b0;
        step(1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) d = 4'($urandom);
            if ($urandom_range(0, 63) == 0) m = 4'($urandom) & 4'($urandom);
            s  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            kv = ($urandom_range(0, 7) == 0);
            ko = 1'($urandom);
            r  = ($urandom_range(0, 299) == 0);
            step(r, s, d, m, kv, ko);
            checks++;
            if (STATE !== 3'(m_state)) begin
                failures++; $display("FAIL rand_state cyc=%0d got=%0d exp=%0d", i, STATE, m_state);
            end
            checks++;
            if (SIREN_OUT !== (m_state == 4)) begin
                failures++; $display("FAIL rand_siren cyc=%0d got=%b exp=%b", i, SIREN_OUT, (m_state == 4));
            end
            checks++;
            if (ARMED_OUT !== (m_state != 0)) begin
                failures++; $display("FAIL rand_armed cyc=%0d got=%b exp=%b", i, ARMED_OUT, (m_state != 0));
            end
            checks++;
            if (TRIG_ZONES !== m_trig) begin
                failures++; $display("FAIL rand_trig cyc=%0d got=%b exp=%b", i, TRIG_ZONES, m_trig);
            end
            checks++;
            if (FAIL_CNT !== 2'(m_fail)) begin
                failures++; $display("FAIL rand_failcnt cyc=%0d got=%0d exp=%0d", i, FAIL_CNT, m_fail);
            end
        end
    endtask

    initial begin
        RST = 1'b1; SENSOR_IN = '0; ZONE_DELAYED = '0; ZONE_MASK = '0;
        KEY_VALID = 1'b0; KEY_OK = 1'b0;
        test_reset();
        test_exit_alarm();
        test_entry_disarm();
        test_entry_timeout();
        test_wrong_codes();
        test_mask();
        test_reset_in_alarm();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alarm_zone_ctrl.md
ALARM_ZONE_CTRL -- requirements
Module: alarm_zone_ctrl

Interface
REQ-001 Parameter N_ZONES, default 4: number of sensor zones (1..16).
REQ-002 Parameter CNT_W, default 18: width of the delay/siren counter.
REQ-003 Parameter EXIT_DELAY, default 15000: cycles spent in EXIT before ARMED.
REQ-004 Parameter ENTRY_DELAY, default 15000: cycles spent in ENTRY before ALARM.
REQ-005 Parameter SIREN_MAX, default 60000: cycles SIREN_OUT stays high per alarm episode.
REQ-006 Parameter MAX_FAILS, default 3: consecutive wrong codes that force ALARM.
REQ-007 CLK  in  1  single clock, all logic rising-edge.
REQ-008 RST  in  1  reset, synchronous, active-high.
REQ-009 SENSOR_IN  in  N_ZONES  1 = zone open; synchronous to CLK (synchronisers are external).
REQ-010 ZONE_DELAYED  in  N_ZONES  1 = delayed (door) zone, 0 = instant (window) zone.
REQ-011 ZONE_MASK  in  N_ZONES  1 = zone bypassed, ignored in all states.
REQ-012 KEY_VALID  in  1  one-cycle pulse: keypad code result available.
REQ-013 KEY_OK  in  1  qualified by KEY_VALID: 1 correct code, 0 wrong code.
REQ-014 STATE  out  3  current state encoding.
REQ-015 SIREN_OUT  out  1  siren drive.
REQ-016 ARMED_OUT  out  1  high in every state except DISARMED.
REQ-017 TRIG_ZONES  out  N_ZONES  latched zones that caused ENTRY/ALARM.
REQ-018 FAIL_CNT  out  2  current consecutive wrong-code count (saturating).

Function
REQ-019 States SHALL be DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4, SILENT=5; codes 6-7 SHALL return to DISARMED next cycle.
REQ-020 Effective trigger vectors: inst = SENSOR_IN & ~ZONE_MASK & ~ZONE_DELAYED; dly = SENSOR_IN & ~ZONE_MASK & ZONE_DELAYED.
REQ-021 Good code (KEY_VALID & KEY_OK) SHALL have highest priority: DISARMED -> EXIT; any other state -> DISARMED, same edge.
REQ-022 EXIT: sensors ignored; after exactly EXIT_DELAY cycles in EXIT -> ARMED.
REQ-023 ARMED: any inst bit -> ALARM; else any dly bit -> ENTRY; inst wins if both.
REQ-024 ENTRY: any inst bit -> ALARM immediately; after exactly ENTRY_DELAY cycles in ENTRY -> ALARM.
REQ-025 ALARM: SIREN_OUT high; after exactly SIREN_MAX cycles -> SILENT.
REQ-026 SILENT: SIREN_OUT low; any inst or dly bit -> ALARM with siren counter reloaded.
REQ-027 Wrong code (KEY_VALID & ~KEY_OK) outside DISARMED SHALL increment FAIL_CNT; reaching MAX_FAILS -> ALARM (from SILENT also re-arms siren); FAIL_CNT cleared on any good code and on entering DISARMED; wrong codes in DISARMED ignored.
REQ-028 One down counter SHALL serve EXIT, ENTRY and ALARM; loaded on every state entry, holds 0 in DISARMED/ARMED/SILENT; no wrap-around.
REQ-029 TRIG_ZONES SHALL OR in (inst|dly) on every edge causing ARMED->ENTRY/ALARM, ENTRY->ALARM or SILENT->ALARM; cleared on entering DISARMED.
REQ-030 STATE, SIREN_OUT, ARMED_OUT, TRIG_ZONES, FAIL_CNT SHALL be registered or decoded from registers only; transitions occur on the edge where the condition is sampled (latency 1 cycle).
REQ-031 KEY_OK without KEY_VALID SHALL have no effect.

Reset
REQ-032 RST high at an edge SHALL force STATE=DISARMED, SIREN_OUT=0, ARMED_OUT=0, TRIG_ZONES=0, FAIL_CNT=0, counter=0, regardless of current state or pending inputs.
REQ-033 Reset mid-ALARM SHALL drop SIREN_OUT on that same edge.

Structure
REQ-034 State encodings and key result codes SHALL live in shared package alarm_pkg.
REQ-035 Counter SHALL be one sub-module, delay_counter (load, enable, CNT_W-bit down count, zero flag).

Verification (N_ZONES=4, EXIT_DELAY=3, ENTRY_DELAY=4, SIREN_MAX=5, MAX_FAILS=3)
REQ-036 Good code in DISARMED -> EXIT 3 cycles -> ARMED; SENSOR_IN=0100 (instant) -> ALARM next edge, TRIG_ZONES=0100, SIREN_OUT high 5 cycles -> SILENT.
REQ-037 ARMED, SENSOR_IN=0001 with ZONE_DELAYED=0001 -> ENTRY; good code at cycle 2 -> DISARMED, SIREN_OUT never high, TRIG_ZONES cleared.
REQ-038 ENTRY with no code -> ALARM exactly 4 cycles after entry; instant zone at ENTRY cycle 1 -> ALARM next edge.
REQ-039 ARMED, three wrong codes -> ALARM on third, FAIL_CNT=3; good code -> DISARMED, FAIL_CNT=0.
REQ-040 ZONE_MASK=1111 in ARMED with SENSOR_IN=1111 -> stays ARMED; good code and sensor same cycle -> DISARMED.
REQ-041 RST asserted in ALARM with KEY_VALID high -> all outputs at reset values next edge.
